ps2_receiver: RTL

PS/2 device-to-host frame receiver. It deserializes the keyboard's 11-bit frames from the raw ps2_clk/ps2_dat pins and produces the byte-plus-strobe pair consumed by the memory/port controller's keyboard path (ps2_data, ps2_hit). The block sits between the board PS/2 pins and the controller's clock50 domain. It is also where the line is checked for glitches, parity errors, framing errors and stalled frames.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_sync_filter.sv | 56 +++++
 rtl/ps2_receiver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame
// geometry and the scan-code prefixes downstream decode looks for.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam int         FRAME_BITS   = 11;
  localparam logic [7:0] KEY_BREAK    = 8'hF0;
  localparam logic [7:0] KEY_EXTENDED = 8'hE0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer followed by a run-length debounce; emits the
// filtered level and a one-cycle pulse on its 1->0 transition.
module ps2_sync_filter #(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER + 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync_d       = {sync_q[0], raw_in};
    run_d        = '0;
    level_d      = level_q;
    level_prev_d = level_q;
    fall_d       = level_prev_q & ~level_q;
    // Count consecutive disagreements; any agreement restarts the run.
    if (sync_q[1] != level_q) begin
      if (run_q == CNT_W'(FILTER - 1)) begin
        level_d = sync_q[1];
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q       <= 2'b11;
      run_q        <= '0;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      fall_q       <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      run_q        <= run_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      fall_q       <= fall_d;
    end
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: deserializes 11-bit frames into a
// byte plus hit strobe, rejecting bad start/parity/stop and stalled frames.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err,
  output logic       busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic             clk_level, clk_fall_raw, clk_fall;
  logic [1:0]       dat_sync_q, dat_sync_d;
  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             parity_ok_q, parity_ok_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       data_q, data_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic             dat_bit;

  ps2_sync_filter #(.FILTER(FILTER)) u_clk_filt (
    .clock  (clock),
    .reset  (reset),
    .raw_in (ps2_clk),
    .level  (clk_level),
    .fall   (clk_fall_raw)
  );

  assign clk_fall = clk_fall_raw & ~clk_level;
  assign dat_bit  = dat_sync_q[1];

  always_comb begin
    dat_sync_d  = {dat_sync_q[0], ps2_dat};
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_ok_d = parity_ok_q;
    data_d      = data_q;
    hit_d       = 1'b0;
    err_d       = 1'b0;
    tmo_d       = (state_q == ST_IDLE || clk_fall) ? '0 : tmo_q + 1'b1;

    // A stall abort wins over a coincident fall, which is then dropped.
    if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT - 1)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else if (clk_fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_bit) begin
            state_d   = ST_DATA;
            shift_d   = '0;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_ok_d = odd_parity_ok(shift_q, dat_bit);
          state_d     = ST_STOP;
        end
        ST_STOP: begin
          if (dat_bit && parity_ok_q) begin
            data_d = shift_q;
            hit_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dat_sync_q  <= 2'b11;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_ok_q <= 1'b0;
      tmo_q       <= '0;
      data_q      <= 8'h00;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dat_sync_q  <= dat_sync_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_ok_q <= parity_ok_d;
      tmo_q       <= tmo_d;
      data_q      <= data_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
    end
  end

  assign ps2_data = data_q;
  assign ps2_hit  = hit_q;
  assign ps2_err  = err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
